// File: rtl/dice_roller_core.sv
// rtl/dice_roller_core.sv - debounced six-die roller producing a 2-digit BCD result
// Buttons are synchronised and debounced; the held die spins its value, coasts, then freezes.
module dice_roller_core #(
  parameter int DEB_CYCLES  = 64,
  parameter int SPIN_CYCLES = 1024,
  parameter int COUNT_UP    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn,
  output logic [3:0] digit10,
  output logic [3:0] digit1,
  output logic [2:0] die_sel,
  output logic       rolling,
  output logic       result_valid
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SW = (SPIN_CYCLES > 0) ? $clog2(SPIN_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] SPIN_LOAD = SW'(SPIN_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ROLL, S_SPIN, S_DONE} state_t;

  // Die size in the same BCD encoding as the display; 100 shows as 00.
  function automatic logic [7:0] n_bcd(input logic [2:0] k);
    case (k)
      3'd0:    n_bcd = 8'h04;
      3'd1:    n_bcd = 8'h06;
      3'd2:    n_bcd = 8'h08;
      3'd3:    n_bcd = 8'h10;
      3'd4:    n_bcd = 8'h20;
      default: n_bcd = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] step_down(input logic [7:0] v, input logic [7:0] n);
    if (v == 8'h01)
      step_down = n;
    else if (v[3:0] == 4'd0)
      step_down = (v[7:4] == 4'd0) ? 8'h99 : {v[7:4] - 4'd1, 4'd9};
    else
      step_down = {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] step_up(input logic [7:0] v, input logic [7:0] n);
    if (v == n)
      step_up = 8'h01;
    else if (v[3:0] == 4'd9)
      step_up = (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
    else
      step_up = {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [5:0]    sync1_q, sync1_d;
  logic [5:0]    sync2_q, sync2_d;
  logic [5:0]    deb_q, deb_d;
  logic [5:0]    deb_prev_q, deb_prev_d;
  logic [CW-1:0] cnt_q [6];
  logic [CW-1:0] cnt_d [6];
  state_t        state_q, state_d;
  logic [7:0]    value_q, value_d;
  logic [2:0]    sel_q, sel_d;
  logic          rolling_q, rolling_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] spin_q, spin_d;

  logic [5:0]    rise;
  logic [2:0]    pick_idx;
  logic [7:0]    stepped;

  always_comb begin
    sync1_d    = btn;
    sync2_d    = sync1_q;
    deb_prev_d = deb_q;
    deb_d      = deb_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST)
          deb_d[i] = sync2_q[i];
        else
          cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Edge detection is against last cycle's debounced level, so a held button never retriggers.
  always_comb begin
    rise     = deb_q & ~deb_prev_q;
    pick_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (rise[i])
        pick_idx = 3'(i);
    end
    stepped = (COUNT_UP != 0) ? step_up(value_q, n_bcd(sel_q))
                              : step_down(value_q, n_bcd(sel_q));
  end

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    sel_d     = sel_q;
    rolling_d = rolling_q;
    valid_d   = 1'b0;
    spin_d    = spin_q;
    case (state_q)
      S_IDLE: begin
        if (|rise) begin
          state_d   = S_ROLL;
          sel_d     = pick_idx;
          value_d   = (COUNT_UP != 0) ? 8'h01 : n_bcd(pick_idx);
          rolling_d = 1'b1;
        end
      end
      S_ROLL: begin
        if (deb_q[sel_q]) begin
          value_d = stepped;
        end else if (SPIN_CYCLES == 0) begin
          state_d   = S_DONE;
          rolling_d = 1'b0;
          valid_d   = 1'b1;
        end else begin
          state_d = S_SPIN;
          spin_d  = SPIN_LOAD;
        end
      end
      S_SPIN: begin
        value_d = stepped;
        spin_d  = spin_q - 1'b1;
        if (spin_q == SW'(1)) begin
          state_d   = S_DONE;
          rolling_d = 1'b0;
          valid_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 6; i++)
        cnt_q[i] <= '0;
      state_q    <= S_IDLE;
      value_q    <= 8'h00;
      sel_q      <= 3'd0;
      rolling_q  <= 1'b0;
      valid_q    <= 1'b0;
      spin_q     <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < 6; i++)
        cnt_q[i] <= cnt_d[i];
      state_q    <= state_d;
      value_q    <= value_d;
      sel_q      <= sel_d;
      rolling_q  <= rolling_d;
      valid_q    <= valid_d;
      spin_q     <= spin_d;
    end
  end

  assign digit10      = value_q[7:4];
  assign digit1       = value_q[3:0];
  assign die_sel      = sel_q;
  assign rolling      = rolling_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_dice_roller_core.sv
// tb/tb_dice_roller_core.sv - bench for dice_roller_core against an integer-valued roll model
// Instance a: down-counting, no spin. Instance b: up-counting, three spin steps.
module tb_dice_roller_core;

  localparam int DEB = 4;
  localparam int IDLE = 0, ROLL = 1, SPIN = 2, DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [5:0] btn_a, btn_b;
  logic [3:0] d10_a, d1_a, d10_b, d1_b;
  logic [2:0] sel_a, sel_b;
  logic       roll_a, roll_b, valid_a, valid_b;

  dice_roller_core #(.DEB_CYCLES(DEB), .SPIN_CYCLES(0), .COUNT_UP(0)) dut_a (
    .clk(clk), .rst_n(rst_a), .btn(btn_a), .digit10(d10_a), .digit1(d1_a),
    .die_sel(sel_a), .rolling(roll_a), .result_valid(valid_a));

  dice_roller_core #(.DEB_CYCLES(DEB), .SPIN_CYCLES(3), .COUNT_UP(1)) dut_b (
    .clk(clk), .rst_n(rst_b), .btn(btn_b), .digit10(d10_b), .digit1(d1_b),
    .die_sel(sel_b), .rolling(roll_b), .result_valid(valid_b));

  int spin_p [2] = '{0, 3};
  int up_p   [2] = '{0, 1};
  int nval   [6] = '{4, 6, 8, 10, 20, 100};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h required 'h%0h", name, act, exp);
    end
  endtask

  // Behavioural model: value kept as a plain integer 1..N, displayed via /10 and %10.
  logic [5:0] m_s1 [2], m_s2 [2], m_deb [2], m_prev [2];
  int         m_run [2][6];
  int         m_mode [2], m_val [2], m_sel [2], m_left [2];
  bit         m_roll [2], m_valid [2];
  bit         m_on = 1'b0;

  function automatic int stepv(input int v, input int n, input int up);
    if (up != 0) return (v % n) + 1;
    return (v == 1) ? n : v - 1;
  endfunction

  always @(posedge clk) begin
    logic [5:0] b, rise;
    logic       r;
    int         k;
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? btn_a : btn_b;
      r = (i == 0) ? rst_a : rst_b;
      if (!r) begin
        m_on = 1'b1;
        m_s1[i] = '0; m_s2[i] = '0; m_deb[i] = '0; m_prev[i] = '0;
        for (int j = 0; j < 6; j++) m_run[i][j] = 0;
        m_mode[i] = IDLE; m_val[i] = 0; m_sel[i] = 0; m_left[i] = 0;
        m_roll[i] = 1'b0; m_valid[i] = 1'b0;
      end else begin
        m_valid[i] = 1'b0;
        case (m_mode[i])
          IDLE: begin
            rise = m_deb[i] & ~m_prev[i];
            if (rise != 0) begin
              k = 0;
              while (!rise[k]) k++;
              m_sel[i]  = k;
              m_val[i]  = (up_p[i] != 0) ? 1 : nval[k];
              m_mode[i] = ROLL;
              m_roll[i] = 1'b1;
            end
          end
          ROLL: begin
            if (m_deb[i][m_sel[i]]) begin
              m_val[i] = stepv(m_val[i], nval[m_sel[i]], up_p[i]);
            end else if (spin_p[i] == 0) begin
              m_mode[i] = DONE; m_valid[i] = 1'b1; m_roll[i] = 1'b0;
            end else begin
              m_mode[i] = SPIN; m_left[i] = spin_p[i];
            end
          end
          SPIN: begin
            m_val[i] = stepv(m_val[i], nval[m_sel[i]], up_p[i]);
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_mode[i] = DONE; m_valid[i] = 1'b1; m_roll[i] = 1'b0;
            end
          end
          default: m_mode[i] = IDLE;
        endcase
        m_prev[i] = m_deb[i];
        for (int j = 0; j < 6; j++) begin
          if (m_s2[i][j] != m_deb[i][j]) begin
            m_run[i][j]++;
            if (m_run[i][j] == DEB) begin
              m_deb[i][j] = m_s2[i][j];
              m_run[i][j] = 0;
            end
          end else begin
            m_run[i][j] = 0;
          end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = b;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("a_digit10", int'(d10_a), (m_val[0] / 10) % 10);
      chk("a_digit1",  int'(d1_a),  m_val[0] % 10);
      chk("a_die_sel", int'(sel_a), m_sel[0]);
      chk("a_rolling", int'(roll_a), int'(m_roll[0]));
      chk("a_valid",   int'(valid_a), int'(m_valid[0]));
      chk("b_digit10", int'(d10_b), (m_val[1] / 10) % 10);
      chk("b_digit1",  int'(d1_b),  m_val[1] % 10);
      chk("b_die_sel", int'(sel_b), m_sel[1]);
      chk("b_rolling", int'(roll_b), int'(m_roll[1]));
      chk("b_valid",   int'(valid_b), int'(m_valid[1]));
    end
  end

  function automatic int digs(input int inst);
    return (inst == 0) ? int'({d10_a, d1_a}) : int'({d10_b, d1_b});
  endfunction

  task automatic wait_roll(input int inst, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (((inst == 0) ? roll_a : roll_b) == 1'b0 && cyc < 60);
    if (((inst == 0) ? roll_a : roll_b) == 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_roll_%0d: rolling got 0 required 1 within 60 cycles", inst);
    end
  endtask

  task automatic wait_valid(input int inst, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (((inst == 0) ? valid_a : valid_b) == 1'b0 && cyc < 200);
    if (((inst == 0) ? valid_a : valid_b) == 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_valid_%0d: result_valid got 0 required 1 within 200 cycles", inst);
    end
  endtask

  logic [7:0] exp1 [8] = '{8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h06, 8'h05};
  int         seq [8];
  int         cyc, seen;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; btn_a = '0; btn_b = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
    chk("reset_digits_a", digs(0), 0);
    chk("reset_sel_a", int'(sel_a), 0);
    chk("reset_roll_b", int'(roll_b), 0);
    repeat (3) @(negedge clk);

    // d6 down, seven steps then release
    btn_a = 6'b000010;
    wait_roll(0, cyc);
    chk("press_latency", cyc, 2 + DEB + 1);
    seq[0] = digs(0);
    @(negedge clk); seq[1] = digs(0); btn_a = '0;
    for (int j = 2; j < 8; j++) begin
      @(negedge clk); seq[j] = digs(0);
    end
    for (int j = 0; j < 8; j++) chk($sformatf("d6_seq%0d", j), seq[j], int'(exp1[j]));
    @(negedge clk);
    chk("d6_valid", int'(valid_a), 1);
    chk("d6_held", digs(0), 'h05);
    repeat (8) @(negedge clk);
    chk("d6_hold_after", digs(0), 'h05);

    // d100 wrap through 01, 00, 99
    btn_a = 6'b100000;
    wait_roll(0, cyc);
    chk("d100_first", digs(0), 'h00);
    for (int j = 1; j <= 101; j++) begin
      @(negedge clk);
      if (j == 1)   chk("d100_j1", digs(0), 'h99);
      if (j == 99)  chk("d100_01", digs(0), 'h01);
      if (j == 100) chk("d100_00", digs(0), 'h00);
      if (j == 101) chk("d100_99", digs(0), 'h99);
    end
    btn_a = '0;
    wait_valid(0, cyc);
    repeat (5) @(negedge clk);

    // d10 first value
    btn_a = 6'b001000;
    wait_roll(0, cyc);
    chk("d10_first", digs(0), 'h10);
    chk("d10_sel", int'(sel_a), 3);
    btn_a = '0;
    wait_valid(0, cyc);
    repeat (5) @(negedge clk);

    // debounce: 3-cycle pulse ignored, 6-cycle pulse rolls d4
    btn_a = 6'b000001;
    repeat (3) @(negedge clk);
    btn_a = '0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (roll_a) seen = 1;
    end
    chk("short_pulse_roll", seen, 0);
    btn_a = 6'b000001;
    cyc = 0;
    while (!roll_a && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 6) btn_a = '0;
    end
    chk("long_pulse_roll", int'(roll_a), 1);
    chk("long_pulse_sel", int'(sel_a), 0);
    chk("long_pulse_first", digs(0), 'h04);
    wait_valid(0, cyc);
    repeat (5) @(negedge clk);

    // simultaneous d8+d20; d20 held past DONE must not retrigger
    btn_a = 6'b010100;
    wait_roll(0, cyc);
    chk("tie_sel", int'(sel_a), 2);
    chk("tie_first", digs(0), 'h08);
    btn_a = 6'b010000;
    wait_valid(0, cyc);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (roll_a) seen = 1;
    end
    chk("held_no_retrigger", seen, 0);
    btn_a = '0;
    repeat (10) @(negedge clk);

    // d20 up on b with spin of 3
    btn_b = 6'b010000;
    wait_roll(1, cyc);
    chk("d20_first", digs(1), 'h01);
    for (int j = 1; j <= 21; j++) begin
      @(negedge clk);
      if (j == 19) chk("d20_top", digs(1), 'h20);
      if (j == 20) chk("d20_wrap", digs(1), 'h01);
    end
    btn_b = '0;
    wait_valid(1, cyc);
    chk("spin_timing", cyc, 10);
    chk("spin_result", digs(1), 'h11);
    repeat (5) @(negedge clk);

    // reset during spin abandons the roll
    btn_b = 6'b000010;
    wait_roll(1, cyc);
    @(negedge clk);
    btn_b = '0;
    repeat (8) @(negedge clk);
    chk("pre_reset_rolling", int'(roll_b), 1);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    chk("rst_roll", int'(roll_b), 0);
    chk("rst_digits", digs(1), 0);
    chk("rst_sel", int'(sel_b), 0);
    chk("rst_valid", int'(valid_b), 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid_b) seen = 1;
    end
    chk("rst_no_valid", seen, 0);

    // randomized presses, bounces and occasional resets on both instances
    for (int it = 0; it < 60; it++) begin
      btn_a = 6'(1 << $urandom_range(0, 5));
      btn_b = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'(1 << $urandom_range(0, 5));
      repeat ($urandom_range(1, 30)) begin
        @(negedge clk);
        if ($urandom_range(0, 7) == 0) btn_a = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) btn_b = 6'($urandom_range(0, 63));
      end
      btn_a = '0; btn_b = '0;
      if ($urandom_range(0, 15) == 0) rst_a = 1'b0;
      if ($urandom_range(0, 15) == 0) rst_b = 1'b0;
      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1;
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
